// File: rtl/tone_pwm_generator_pkg.sv
// Shared types and elaboration helpers for the buzzer tone generator.
// Holds the controller state encoding and the clock/duty defaults.
package tone_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV_PERIOD,
        DIV_HIGH,
        RUN
    } tone_state_t;

    localparam longint unsigned CLK_HZ_DEF   = 100_000_000;
    localparam longint unsigned DUTY_PCT_DEF = 70;

    function automatic logic [63:0] high_num(
        input logic [63:0] clk_hz,
        input logic [63:0] duty_pct
    );
        return (clk_hz * duty_pct) / 64'd100;
    endfunction

endpackage

// File: rtl/tone_pwm_generator_if.sv
// Melody sequencer to tone generator link: request side and buzzer side.
// The sequencer is the master, the tone generator is the slave.
interface tone_pwm_generator_if #(
    parameter int FREQ_W = 20
);
    logic              enable;
    logic [FREQ_W-1:0] freq;
    logic              buzzer_out;
    logic              tone_active;

    modport master (
        output enable,
        output freq,
        input  buzzer_out,
        input  tone_active
    );

    modport slave (
        input  enable,
        input  freq,
        output buzzer_out,
        output tone_active
    );
endinterface

// File: rtl/tone_pwm_generator_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, W cycles per result.
// done pulses for one cycle; start while busy restarts with the new operands.
module seq_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W:0]    shifted;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        shifted = {rem_q, quo_q[W-1]};
        if (abort) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
            cnt_d  = CW'(W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            // Remainder stays below the divisor, so W bits always hold it.
            if (shifted >= {1'b0, dvs_q}) begin
                rem_d = W'(shifted - {1'b0, dvs_q});
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = shifted[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/tone_pwm_generator.sv
// Buzzer square-wave generator: Hz to cycle counts via a shared divider,
// with shadow registers so note changes land only on a period boundary.
module tone_pwm_generator
    import tone_pkg::*;
#(
    parameter longint unsigned CLK_HZ   = CLK_HZ_DEF,
    parameter longint unsigned DUTY_PCT = DUTY_PCT_DEF,
    parameter int              FREQ_W   = 20,
    parameter int              CNT_W    = 32
) (
    input logic                 clk,
    input logic                 reset,
    tone_pwm_generator_if.slave io
);
    localparam logic [63:0] HIGH_NUM64 = high_num(CLK_HZ, DUTY_PCT);
    localparam logic [CNT_W-1:0] PER_NUM  = CNT_W'(CLK_HZ);
    localparam logic [CNT_W-1:0] HIGH_NUM = CNT_W'(HIGH_NUM64);

    if ((HIGH_NUM64 >> CNT_W) != 64'd0 || (64'(CLK_HZ) >> CNT_W) != 64'd0) begin : g_num_chk
        $error("tone_pwm_generator: divider numerators do not fit CNT_W");
    end
    if (DUTY_PCT < 1 || DUTY_PCT > 99) begin : g_duty_chk
        $error("tone_pwm_generator: DUTY_PCT outside 1..99");
    end

    tone_state_t       state_q, state_d;
    logic [FREQ_W-1:0] req_freq_q, req_freq_d;
    logic [CNT_W-1:0]  per_act_q, per_act_d;
    logic [CNT_W-1:0]  high_act_q, high_act_d;
    logic [CNT_W-1:0]  per_sh_q, per_sh_d;
    logic [CNT_W-1:0]  high_sh_q, high_sh_d;
    logic [CNT_W-1:0]  per_tmp_q, per_tmp_d;
    logic [CNT_W-1:0]  phase_q, phase_d;
    logic              pending_q, pending_d;
    logic              bg_busy_q, bg_busy_d;
    logic              bg_high_q, bg_high_d;
    logic              buzz_q, buzz_d;
    logic              active_q, active_d;

    logic              div_start, div_abort, div_done;
    logic              div_high_sel, div_from_in;
    logic [CNT_W-1:0]  div_quo, div_dividend, div_divisor;
    logic [CNT_W-1:0]  per_c, high_c, high_next;
    logic              go, new_f, wrap;

    function automatic logic [CNT_W-1:0] clamp_per(input logic [CNT_W-1:0] p);
        return (p < CNT_W'(2)) ? CNT_W'(2) : p;
    endfunction

    function automatic logic [CNT_W-1:0] clamp_high(
        input logic [CNT_W-1:0] h,
        input logic [CNT_W-1:0] p
    );
        logic [CNT_W-1:0] r;
        r = (h == '0) ? CNT_W'(1) : h;
        if (r >= p) r = p - 1'b1;
        return r;
    endfunction

    seq_divider #(.W(CNT_W)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quo),
        .done     (div_done)
    );

    assign div_dividend = div_high_sel ? HIGH_NUM : PER_NUM;
    assign div_divisor  = CNT_W'(div_from_in ? io.freq : req_freq_q);

    always_comb begin
        state_d      = state_q;
        req_freq_d   = req_freq_q;
        per_act_d    = per_act_q;
        high_act_d   = high_act_q;
        per_sh_d     = per_sh_q;
        high_sh_d    = high_sh_q;
        per_tmp_d    = per_tmp_q;
        phase_d      = phase_q;
        pending_d    = pending_q;
        bg_busy_d    = bg_busy_q;
        bg_high_d    = bg_high_q;
        buzz_d       = buzz_q;
        active_d     = active_q;
        div_start    = 1'b0;
        div_abort    = 1'b0;
        div_high_sel = 1'b0;
        div_from_in  = 1'b0;
        go           = io.enable && (io.freq != '0);
        new_f        = io.freq != req_freq_q;
        per_c        = clamp_per(per_tmp_q);
        high_c       = clamp_high(div_quo, per_c);
        wrap         = phase_q == per_act_q - 1'b1;
        high_next    = high_act_q;

        if (!go) begin
            state_d   = IDLE;
            phase_d   = '0;
            buzz_d    = 1'b0;
            active_d  = 1'b0;
            pending_d = 1'b0;
            bg_busy_d = 1'b0;
            bg_high_d = 1'b0;
            div_abort = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    req_freq_d  = io.freq;
                    div_start   = 1'b1;
                    div_from_in = 1'b1;
                    state_d     = DIV_PERIOD;
                end
                DIV_PERIOD: begin
                    if (new_f) begin
                        req_freq_d  = io.freq;
                        div_start   = 1'b1;
                        div_from_in = 1'b1;
                    end else if (div_done) begin
                        per_tmp_d    = div_quo;
                        div_start    = 1'b1;
                        div_high_sel = 1'b1;
                        state_d      = DIV_HIGH;
                    end
                end
                DIV_HIGH: begin
                    if (new_f) begin
                        req_freq_d  = io.freq;
                        div_start   = 1'b1;
                        div_from_in = 1'b1;
                        state_d     = DIV_PERIOD;
                    end else if (div_done) begin
                        per_act_d  = per_c;
                        high_act_d = high_c;
                        phase_d    = '0;
                        buzz_d     = 1'b1;
                        active_d   = 1'b1;
                        state_d    = RUN;
                    end
                end
                RUN: begin
                    phase_d  = wrap ? '0 : phase_q + 1'b1;
                    active_d = 1'b1;
                    if (wrap && pending_q) begin
                        per_act_d  = per_sh_q;
                        high_act_d = high_sh_q;
                        high_next  = high_sh_q;
                        pending_d  = 1'b0;
                    end
                    buzz_d = phase_d < high_next;
                    // A newer note always supersedes any result still in flight.
                    if (new_f) begin
                        req_freq_d  = io.freq;
                        div_start   = 1'b1;
                        div_from_in = 1'b1;
                        bg_busy_d   = 1'b1;
                        bg_high_d   = 1'b0;
                        pending_d   = 1'b0;
                    end else if (bg_busy_q && div_done) begin
                        if (!bg_high_q) begin
                            per_tmp_d    = div_quo;
                            div_start    = 1'b1;
                            div_high_sel = 1'b1;
                            bg_high_d    = 1'b1;
                        end else begin
                            per_sh_d  = per_c;
                            high_sh_d = high_c;
                            pending_d = 1'b1;
                            bg_busy_d = 1'b0;
                            bg_high_d = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_freq_q <= '0;
            per_act_q  <= '0;
            high_act_q <= '0;
            per_sh_q   <= '0;
            high_sh_q  <= '0;
            per_tmp_q  <= '0;
            phase_q    <= '0;
            pending_q  <= 1'b0;
            bg_busy_q  <= 1'b0;
            bg_high_q  <= 1'b0;
            buzz_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_freq_q <= req_freq_d;
            per_act_q  <= per_act_d;
            high_act_q <= high_act_d;
            per_sh_q   <= per_sh_d;
            high_sh_q  <= high_sh_d;
            per_tmp_q  <= per_tmp_d;
            phase_q    <= phase_d;
            pending_q  <= pending_d;
            bg_busy_q  <= bg_busy_d;
            bg_high_q  <= bg_high_d;
            buzz_q     <= buzz_d;
            active_q   <= active_d;
        end
    end

    assign io.buzzer_out  = buzz_q;
    assign io.tone_active = active_q;

endmodule
